// File: rtl/mac_acc_drain.sv
// mac_acc_drain: consumer end of the MAC array accumulator interface.
// Snapshots the MAC_WIDTH x MAC_WIDTH accumulator bus, requantizes each
// element (rounding right-shift, then saturation to signed OUT_WIDTH), streams
// one row per valid/ready beat and finally pulses clear_acc/done for a cycle.
//
// Optional feature macro: MAC_DRAIN_RELU_EN (clamp negative results to 0
// before saturation). Undefined by default.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          request one drain (accepted only when idle)
//   shift          requantization right-shift, latched on capture
//   acc_valid      accumulator bus valid
//   accumulators   element (i,j) at [(i*MAC_WIDTH+j)*ACC_WIDTH +: ACC_WIDTH]
//   out_data       requantized row (combinational from snapshot), col j at [j*OUT_WIDTH +: OUT_WIDTH]
//   out_row        row index on out_data
//   out_valid      beat valid; out_ready accepts it
//   out_last       final row marker
//   busy           drain in progress
//   clear_acc      one-cycle pulse after the last row is accepted
//   done           one-cycle pulse coincident with clear_acc
module mac_acc_drain #(
  parameter int unsigned MAC_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned OUT_WIDTH   = 8,
  parameter int unsigned SHIFT_WIDTH = 5,
  localparam int unsigned ROW_W      = $clog2(MAC_WIDTH)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [SHIFT_WIDTH-1:0]                 shift,
  input  logic                                   acc_valid,
  input  logic [MAC_WIDTH*MAC_WIDTH*ACC_WIDTH-1:0] accumulators,
  output logic [MAC_WIDTH*OUT_WIDTH-1:0]         out_data,
  output logic [ROW_W-1:0]                       out_row,
  output logic                                   out_valid,
  output logic                                   out_last,
  input  logic                                   out_ready,
  output logic                                   busy,
  output logic                                   clear_acc,
  output logic                                   done
);

  localparam int unsigned ROW_BITS = MAC_WIDTH * ACC_WIDTH;
  localparam int unsigned EXT_W    = ACC_WIDTH + 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MAC_WIDTH - 1);
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_STREAM,
    S_CLEAR
  } state_t;

  state_t                   state;
  logic [SHIFT_WIDTH-1:0]   shift_q;
  logic [ROW_BITS-1:0]      snap_rows [MAC_WIDTH];
  logic                     capture_c;
  logic [ROW_BITS-1:0]      row_sel;
  logic signed [EXT_W-1:0]  rnd;
  logic signed [EXT_W-1:0]  xe;
  logic signed [EXT_W-1:0]  r;

  // Snapshot is taken when a pending or fresh request meets valid data
  assign capture_c = acc_valid && (((state == S_IDLE) && start) || (state == S_WAIT));

  // Snapshot and shift registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      for (int i = 0; i < MAC_WIDTH; i++) snap_rows[i] <= '0;
    end else if (capture_c) begin
      shift_q <= shift;
      for (int i = 0; i < MAC_WIDTH; i++) snap_rows[i] <= accumulators[i*ROW_BITS +: ROW_BITS];
    end
  end

  // Control FSM with registered handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_row   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      clear_acc <= 1'b0;
      done      <= 1'b0;
    end else begin
      clear_acc <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (acc_valid) begin
              state     <= S_STREAM;
              out_valid <= 1'b1;
              out_row   <= '0;
              out_last  <= (LAST_ROW == '0);
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (acc_valid) begin
            state     <= S_STREAM;
            out_valid <= 1'b1;
            out_row   <= '0;
            out_last  <= (LAST_ROW == '0);
          end
        end
        S_STREAM: begin
          // out_valid is always high here, so out_ready alone marks a transfer
          if (out_ready) begin
            if (out_last) begin
              state     <= S_CLEAR;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_row   <= '0;
              clear_acc <= 1'b1;
              done      <= 1'b1;
            end else begin
              out_row  <= out_row + ROW_W'(1);
              out_last <= ((out_row + ROW_W'(1)) == LAST_ROW);
            end
          end
        end
        S_CLEAR: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign row_sel = snap_rows[out_row];
  assign rnd     = EXT_W'(1) << (shift_q - SHIFT_WIDTH'(1));

  // Requantize the selected row; one extra bit keeps x + rounding bias from wrapping
  always_comb begin
    out_data = '0;
    xe       = '0;
    r        = '0;
    for (int j = 0; j < MAC_WIDTH; j++) begin
      xe = {row_sel[j*ACC_WIDTH + ACC_WIDTH - 1], row_sel[j*ACC_WIDTH +: ACC_WIDTH]};
      if (shift_q == '0) r = xe;
      else               r = (xe + rnd) >>> shift_q;
`ifdef MAC_DRAIN_RELU_EN
      if (r[EXT_W-1]) r = '0;
`endif
      if (r > SAT_MAX)      r = SAT_MAX;
      else if (r < SAT_MIN) r = SAT_MIN;
      out_data[j*OUT_WIDTH +: OUT_WIDTH] = r[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: doc/mac_acc_drain.md
Name: mac_acc_drain

Overview:
- Consumer end of the MAC array accumulator interface.
- Snapshots the flattened MAC_WIDTH x MAC_WIDTH accumulator bus when the array signals valid.
- Requantizes each 32-bit accumulator to a signed OUT_WIDTH value using rounding right-shift and saturation.
- Streams the result one row per beat over a valid/ready interface, then pulses clear_acc back to the array for the next tile.

Parameters:
- MAC_WIDTH, 8, array dimension (rows and columns).
- ACC_WIDTH, 32, accumulator width, signed two's complement.
- OUT_WIDTH, 8, output element width, signed.
- SHIFT_WIDTH, 5, width of the requantization shift amount.
- ROW_W, $clog2(MAC_WIDTH), localparam, width of the row index.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request one drain; accepted only in IDLE
- shift  input  SHIFT_WIDTH  right-shift amount; latched on capture
- acc_valid  input  1  accumulator bus valid (array valid_out)
- accumulators  input  MAC_WIDTH*MAC_WIDTH*ACC_WIDTH  element (i,j) at bits [(i*MAC_WIDTH+j)*ACC_WIDTH +: ACC_WIDTH]
- out_data  output  MAC_WIDTH*OUT_WIDTH  requantized row; column j at bits [j*OUT_WIDTH +: OUT_WIDTH]
- out_row  output  ROW_W  index of the row on out_data
- out_valid  output  1  out_data is valid
- out_last  output  1  high with the final row (MAC_WIDTH-1)
- out_ready  input  1  downstream accepts the beat
- busy  output  1  high in any state other than IDLE
- clear_acc  output  1  one-cycle pulse to the array after the last row is accepted
- done  output  1  one-cycle pulse, coincident with clear_acc

Behaviour:
- Reset values: all outputs 0, snapshot register 0, state IDLE.
- Reset is asynchronous and takes effect at any point, including mid-stream. No clear_acc is issued on reset.
- States and transitions:
  - IDLE: on start with acc_valid=1 in the same cycle, capture and go to STREAM. On start with acc_valid=0, go to WAIT.
  - WAIT: on the first cycle with acc_valid=1, capture and go to STREAM.
  - STREAM: row counter starts at 0. A beat transfers when out_valid && out_ready. On transfer with row < MAC_WIDTH-1, increment the row. On transfer of row MAC_WIDTH-1, go to CLEAR.
  - CLEAR: clear_acc=1 and done=1 for exactly one cycle, then return to IDLE.
- Capture: in the capture cycle, register all MAC_WIDTH² accumulators and shift.
- Timing: if capture happens at cycle T, out_valid rises at T+1 with row 0.
- Minimum drain time with out_ready held high:
  - MAC_WIDTH beats (T+1 to T+MAC_WIDTH).
  - CLEAR at T+MAC_WIDTH+1.
  - IDLE at T+MAC_WIDTH+2.
- Handshake rules:
  - out_valid stays high throughout STREAM.
  - out_data, out_row and out_last hold stable while out_valid && !out_ready.
  - out_valid never drops without a transfer.
- Requantization, per element x (signed ACC_WIDTH), computed in ACC_WIDTH+1 bits to avoid overflow:
  - r = (shift==0) ? x : (x + (1 << (shift-1))) >>> shift. This is round-half-up, arithmetic shift.
  - Saturate r to [-(2^(OUT_WIDTH-1)), 2^(OUT_WIDTH-1)-1].
- Requantization is combinational from the snapshot row selected by out_row, driving out_data directly.
- Ignored inputs:
  - start while busy is ignored with no side effect.
  - acc_valid outside IDLE and WAIT is ignored; the snapshot is not overwritten.
- shift changes after capture have no effect on the drain in progress.
- busy is high in WAIT, STREAM and CLEAR.

Optional Feature:
- Macro: MAC_DRAIN_RELU_EN.
- Defined: r is clamped to 0 when negative, before saturation, so the output range is [0, 2^(OUT_WIDTH-1)-1].
- Undefined: full signed range; no ReLU logic is present.
- All other timing is identical in both configurations.

Test Plan:
1. All accumulators = 1000, shift=3, start with acc_valid=1 at T, out_ready=1:
   - Every column reads 0x7D (125) on rows 0..7 at T+1..T+8.
   - out_last at T+8.
   - clear_acc and done high at T+9 only.
   - busy low at T+10.
2. Saturation, shift=0: element 40000 -> 0x7F; element -40000 -> 0x80; element -128 -> 0x80; element 127 -> 0x7F.
3. Rounding, shift=1: 5 -> 3; -5 -> 0xFE (-2); -1 -> 0x00; 0x7FFFFFFF with shift=31 -> 1 (no wrap in the +1 stage).
4. Backpressure: drop out_ready for 3 cycles while row 2 is presented.
   - out_row=2 and out_data hold unchanged for those cycles.
   - The total stream stretches by 3 cycles.
   - clear_acc appears only after row 7 is accepted.
5. WAIT and ignored inputs: start with acc_valid=0, then acc_valid pulses 4 cycles later.
   - Capture happens in that pulse cycle; out_valid rises the next cycle.
   - A second start during STREAM is ignored, and changed accumulators/acc_valid during STREAM do not alter out_data.
6. Reset mid-stream: assert rst_n=0 while row 4 is presented.
   - All outputs go to 0 immediately.
   - State is IDLE after release, and clear_acc is never pulsed.
   - With MAC_DRAIN_RELU_EN, element -40000 -> 0x00.
